// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target core and its register-bus sequencer.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_W = 8;

  // 7-bit target address the core answers to unless overridden.
  localparam logic [6:0] I2C_DEFAULT_TARGET_ADDR = 7'h42;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PTR      = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Turns I2C target byte events into register-bus writes and reads.
// Register bus: reg_we_o/reg_re_o are single-cycle strobes qualified by reg_addr_o;
// reg_rvalid_i returns read data any number of cycles (>=1) after reg_re_o.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned PTR_RESET = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [I2C_BYTE_W-1:0] i2c_rx_byte_data_i,
  input  logic                  i2c_rx_byte_valid_i,
  input  logic                  i2c_transaction_start_i,
  input  logic                  i2c_transaction_stop_i,
  input  logic                  i2c_tx_byte_req_i,
  output logic [I2C_BYTE_W-1:0] i2c_tx_byte_data_o,
  output logic                  i2c_tx_byte_valid_o,
  output logic [ADDR_W-1:0]     reg_addr_o,
  output logic [I2C_BYTE_W-1:0] reg_wdata_o,
  output logic                  reg_we_o,
  output logic                  reg_re_o,
  input  logic [I2C_BYTE_W-1:0] reg_rdata_i,
  input  logic                  reg_rvalid_i,
  output logic                  busy_o,
  output logic                  err_o
);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [I2C_BYTE_W-1:0] wdata_q, wdata_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [I2C_BYTE_W-1:0] tx_data_q, tx_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= ADDR_W'(PTR_RESET);
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;

    // The pointer advances after the write strobe so reg_addr_o is correct during it.
    if (we_q) ptr_d = ptr_q + ADDR_W'(1);

    if (i2c_transaction_stop_i) begin
      state_d = ST_IDLE;
    end else if (i2c_transaction_start_i) begin
      state_d = ST_PTR;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i2c_tx_byte_req_i || i2c_rx_byte_valid_i) err_d = 1'b1;
        end
        ST_PTR: begin
          if (i2c_tx_byte_req_i) begin
            state_d = ST_RD_ISSUE;
          end else if (i2c_rx_byte_valid_i) begin
            ptr_d   = ADDR_W'(i2c_rx_byte_data_i);
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (i2c_tx_byte_req_i) begin
            state_d = ST_RD_ISSUE;
          end else if (i2c_rx_byte_valid_i) begin
            we_d    = 1'b1;
            wdata_d = i2c_rx_byte_data_i;
          end
        end
        ST_RD_ISSUE: begin
          if (i2c_tx_byte_req_i || i2c_rx_byte_valid_i) err_d = 1'b1;
          state_d = ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (i2c_tx_byte_req_i || i2c_rx_byte_valid_i) err_d = 1'b1;
          if (reg_rvalid_i) begin
            tx_data_d  = reg_rdata_i;
            tx_valid_d = 1'b1;
            ptr_d      = ptr_q + ADDR_W'(1);
            state_d    = ST_WRITE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign reg_addr_o          = ptr_q;
  assign reg_wdata_o         = wdata_q;
  assign reg_we_o            = we_q;
  assign reg_re_o            = (state_q == ST_RD_ISSUE);
  assign i2c_tx_byte_data_o  = tx_data_q;
  assign i2c_tx_byte_valid_o = tx_valid_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign err_o               = err_q;

endmodule
